// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the fetch unit and decoder: widths, instruction
// field positions and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam int ADDR_W      = 8;
  localparam int INSTR_W     = 16;
  localparam int OPCODE_MSB  = 15;
  localparam int OPCODE_LSB  = 8;
  localparam int OPERAND_MSB = 7;
  localparam int OPERAND_LSB = 0;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [OPCODE_MSB-OPCODE_LSB:0] opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Decoder-side field split of a fetched instruction word.
  function automatic opcode_t instr_opcode(input instr_t instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic addr_t instr_operand(input instr_t instr);
    return instr[OPERAND_MSB:OPERAND_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the instruction-memory port, decoder handshake and redirect
// controls seen by the fetch unit.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic   imem_req;
  addr_t  imem_addr;
  logic   imem_ack;
  instr_t imem_rdata;
  instr_t instr_out;
  logic   instr_valid;
  logic   instr_ready;
  logic   jump_en;
  addr_t  jump_target;
  logic   halt;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_out,
    output instr_valid,
    input  instr_ready,
    input  jump_en,
    input  jump_target,
    input  halt
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_out,
    input  instr_valid,
    output instr_ready,
    output jump_en,
    output jump_target,
    input  halt
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, a one-entry
// holding register towards the decoder, and jump redirect with flush.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  logic         flush_q, flush_d;
  logic         req_q, req_d;
  addr_t        addr_q, addr_d;
  instr_t       instr_q, instr_d;
  logic         valid_q, valid_d;
  addr_t        pc_redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_d     = flush_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    pc_redirect = bus.jump_en ? bus.jump_target : pc_q;

    unique case (state_q)
      ST_IDLE: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        pc_d    = pc_redirect;
        if (!bus.halt) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
          addr_d  = pc_redirect;
        end
      end

      ST_FETCH: begin
        // Request and address stay frozen until the memory answers.
        if (bus.imem_ack) begin
          if (flush_q || bus.jump_en) begin
            flush_d = 1'b0;
            pc_d    = pc_redirect;
            addr_d  = pc_redirect;
            req_d   = 1'b1;
          end else begin
            instr_d = bus.imem_rdata;
            pc_d    = pc_q + 8'd1;
            req_d   = 1'b0;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (bus.jump_en) begin
          pc_d    = bus.jump_target;
          flush_d = 1'b1;
        end
      end

      ST_HOLD: begin
        // A jump drops the held word even if the decoder takes it this cycle.
        if (bus.jump_en || bus.instr_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_redirect;
          if (!bus.halt) begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
            addr_d  = pc_redirect;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
        flush_d = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch: per-cycle input/expected
// records plus hand sequences for asynchronous reset and stray acks.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        ready;
    logic        jmp;
    logic [7:0]  tgt;
    logic        halt;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic [15:0] rd, input logic rdy,
                                input logic j, input logic [7:0] t, input logic h);
    bus.imem_ack    = a;
    bus.imem_rdata  = rd;
    bus.instr_ready = rdy;
    bus.jump_en     = j;
    bus.jump_target = t;
    bus.halt        = h;
  endtask

  task automatic addv(input logic a, input logic [15:0] rd, input logic rdy, input logic j,
                      input logic [7:0] t, input logic h, input logic er, input logic [7:0] ea,
                      input logic ev, input logic [15:0] ei);
    vec_t v;
    v.ack = a; v.rdata = rd; v.ready = rdy; v.jmp = j; v.tgt = t; v.halt = h;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Memory word at address a is {a ^ 8'h5A, a}.
    //   ack rdata    rdy jmp tgt    halt  req addr   vld instr
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h00, 0, 16'h0000);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h00, 0, 16'h0000);
    addv(1, 16'h5A00, 1, 0, 8'h00, 0,    0, 8'h00, 1, 16'h5A00);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h01, 0, 16'h0000);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h01, 0, 16'h0000);
    addv(1, 16'h5B01, 1, 0, 8'h00, 0,    0, 8'h01, 1, 16'h5B01);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h02, 0, 16'h0000);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h02, 0, 16'h0000);
    addv(1, 16'h5802, 1, 0, 8'h00, 0,    0, 8'h02, 1, 16'h5802);
    for (int k = 0; k < 5; k++)
      addv(0, 16'h0000, 0, 0, 8'h00, 0,  0, 8'h02, 1, 16'h5802);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h03, 0, 16'h0000);
    for (int k = 0; k < 3; k++)
      addv(0, 16'h0000, 1, 0, 8'h00, 0,  1, 8'h03, 0, 16'h0000);
    addv(1, 16'h5903, 1, 0, 8'h00, 0,    0, 8'h03, 1, 16'h5903);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h04, 0, 16'h0000);
    addv(1, 16'h5E04, 1, 0, 8'h00, 0,    0, 8'h04, 1, 16'h5E04);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h05, 0, 16'h0000);
    addv(0, 16'h0000, 1, 1, 8'h40, 0,    1, 8'h05, 0, 16'h0000);
    addv(1, 16'h5F05, 1, 0, 8'h00, 0,    1, 8'h40, 0, 16'h0000);
    addv(1, 16'h1A40, 1, 0, 8'h00, 0,    0, 8'h40, 1, 16'h1A40);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h41, 0, 16'h0000);
    addv(1, 16'h1B41, 1, 1, 8'h80, 0,    1, 8'h80, 0, 16'h0000);
    addv(1, 16'hDA80, 1, 0, 8'h00, 0,    0, 8'h80, 1, 16'hDA80);
    addv(0, 16'h0000, 1, 1, 8'hFE, 0,    1, 8'hFE, 0, 16'h0000);
    addv(1, 16'hA4FE, 1, 0, 8'h00, 0,    0, 8'hFE, 1, 16'hA4FE);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'hFF, 0, 16'h0000);
    addv(1, 16'hA5FF, 1, 0, 8'h00, 0,    0, 8'hFF, 1, 16'hA5FF);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h00, 0, 16'h0000);
    addv(1, 16'h5A00, 1, 0, 8'h00, 1,    0, 8'h00, 1, 16'h5A00);
    addv(0, 16'h0000, 1, 0, 8'h00, 1,    0, 8'h00, 0, 16'h0000);
    addv(0, 16'h0000, 1, 0, 8'h00, 1,    0, 8'h00, 0, 16'h0000);
    addv(0, 16'h0000, 1, 1, 8'h10, 1,    0, 8'h00, 0, 16'h0000);
    addv(0, 16'h0000, 1, 0, 8'h00, 0,    1, 8'h10, 0, 16'h0000);

    reset = 1'b1;
    apply_stimulus(0, 16'h0000, 1, 0, 8'h00, 0);
    tick();
    tick();
    check_output("rst_req",   {15'd0, bus.imem_req},    16'd0);
    check_output("rst_addr",  {8'd0, bus.imem_addr},    16'd0);
    check_output("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
    check_output("rst_instr", bus.instr_out,            16'h0000);

    reset = 1'b0;
    #1;
    check_output("rel_req_before_edge", {15'd0, bus.imem_req}, 16'd0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].ack, vecs[i].rdata, vecs[i].ready,
                     vecs[i].jmp, vecs[i].tgt, vecs[i].halt);
      tick();
      check_output($sformatf("v%0d_req", i),   {15'd0, bus.imem_req},    {15'd0, vecs[i].exp_req});
      check_output($sformatf("v%0d_valid", i), {15'd0, bus.instr_valid}, {15'd0, vecs[i].exp_valid});
      if (vecs[i].exp_req)
        check_output($sformatf("v%0d_addr", i), {8'd0, bus.imem_addr}, {8'd0, vecs[i].exp_addr});
      if (vecs[i].exp_valid)
        check_output($sformatf("v%0d_instr", i), bus.instr_out, vecs[i].exp_instr);
    end

    // Reset in the middle of the fetch to 8'h10, then a stray ack right after release.
    apply_stimulus(0, 16'h0000, 1, 0, 8'h00, 0);
    tick();
    reset = 1'b1;
    #1;
    check_output("async_rst_req",   {15'd0, bus.imem_req},    16'd0);
    check_output("async_rst_addr",  {8'd0, bus.imem_addr},    16'd0);
    check_output("async_rst_valid", {15'd0, bus.instr_valid}, 16'd0);
    apply_stimulus(1, 16'hBEEF, 1, 0, 8'h00, 0);
    tick();
    reset = 1'b0;
    #1;
    check_output("rerel_req_before_edge", {15'd0, bus.imem_req}, 16'd0);
    tick();
    check_output("stray_ack_valid", {15'd0, bus.instr_valid}, 16'd0);
    check_output("stray_ack_req",   {15'd0, bus.imem_req},    16'd1);
    check_output("stray_ack_addr",  {8'd0, bus.imem_addr},    16'h0000);
    apply_stimulus(0, 16'h0000, 1, 0, 8'h00, 0);
    tick();
    check_output("post_stray_valid", {15'd0, bus.instr_valid}, 16'd0);
    check_output("post_stray_addr",  {8'd0, bus.imem_addr},    16'h0000);
    apply_stimulus(1, 16'h5A00, 1, 0, 8'h00, 0);
    tick();
    check_output("post_stray_data", bus.instr_out, 16'h5A00);
    check_output("post_stray_opcode", {8'd0, instr_opcode(bus.instr_out)}, 16'h005A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
